imem_wr_arbiter: RTL and testbench
==================================

IMEM_WR_ARBITER -- requirements
Module: imem_wr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, the instruction-memory word-address width.
REQ-002 SHALL have parameter MAX_BURST, default 8, the maximum accepted beats per locked grant (legal range 2..255).
REQ-003 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports r0_valid/r1_valid  input  1  requester 0 (CPU store path) / requester 1 (bootloader) write request.
REQ-006 SHALL have ports r0_ready/r1_ready  output  1  request accepted this cycle when valid&&ready.
REQ-007 SHALL have ports r0_addr/r1_addr  input  ADDR_WIDTH  word address.
REQ-008 SHALL have ports r0_data/r1_data  input  32  write data.
REQ-009 SHALL have ports r0_wea/r1_wea  input  4  byte enables; bit i covers data[8i+7:8i].
REQ-010 SHALL have ports r0_lock/r1_lock  input  1  requester holds the grant after the current beat.
REQ-011 SHALL have ports ena  output  1, wea  output  4, addra  output  ADDR_WIDTH, dina  output  32: registered memory write port.
REQ-012 SHALL have port rd_addr  input  ADDR_WIDTH  memory read-port address for this cycle.
REQ-013 SHALL have port rd_hazard  output  1  the read at rd_addr this cycle returns pre-write (stale) data.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT0, GRANT1, plus a 1-bit last_served register and a beat counter sized for MAX_BURST.
REQ-015 In IDLE, ready SHALL be combinational: only r0 valid -> r0_ready=1; only r1 valid -> r1_ready=1; both valid -> ready only to the requester != last_served; neither valid -> both ready 0.
REQ-016 In GRANTi, only ri_ready SHALL be asserted, equal to 1 regardless of ri_valid; the other ready SHALL be 0.
REQ-017 On every accepted beat, last_served SHALL update to the accepted requester index.
REQ-018 IDLE -> GRANTi SHALL occur on an accepted beat from i with ri_lock=1; the beat counter is then set to 1.
REQ-019 In GRANTi, each accepted beat SHALL increment the beat counter.
REQ-020 GRANTi -> IDLE SHALL occur on an accepted beat with ri_lock=0, on the accepted beat that brings the counter to MAX_BURST (forced release regardless of lock), or in any cycle with ri_valid=0 and ri_lock=0.
REQ-021 After a forced release, the other requester, if valid, SHALL win the next IDLE arbitration by last_served rule.
REQ-022 The cycle after an accepted beat, ena SHALL be 1, with wea/addra/dina equal to the accepted wea/addr/data; latency is exactly 1 cycle, throughput 1 beat/cycle.
REQ-023 An accepted beat with wea=4'b0000 SHALL be consumed and SHALL produce ena=0, wea=0 the next cycle.
REQ-024 In cycles with no accepted beat on the previous edge, ena and wea SHALL be 0, and addra/dina SHALL hold their values.
REQ-025 rd_hazard SHALL be combinational and equal to ena && (wea!=0) && (addra==rd_addr).
REQ-026 The block SHALL never accept two beats in one cycle.

Reset
REQ-027 While rst=1 at a clock edge: state SHALL become IDLE, last_served SHALL become 1 (so r0 wins the first tie), the beat counter SHALL become 0, and ena, wea, addra, and dina SHALL become 0.
REQ-028 While rst=1, r0_ready and r1_ready SHALL be 0 and no beat SHALL be accepted.
REQ-029 Reset asserted mid-burst SHALL abandon the grant; no write is issued in the cycle after the reset edge.

Verification
REQ-030 Reset then r0 and r1 both valid with lock=0 for 4 cycles -> grants r0,r1,r0,r1; ena=1 each following cycle with matching addr/data.
REQ-031 r1 locked burst (lock=1, valid continuous) while r0 valid, MAX_BURST=8 -> 8 consecutive r1 beats, r0_ready=0 throughout, r0 granted on the 9th cycle.
REQ-032 r0 beat addr=0x0010, data=0xDEADBEEF, wea=4'b0101 -> next cycle ena=1, addra=0x0010, dina=0xDEADBEEF, wea=4'b0101; with rd_addr=0x0010 rd_hazard=1, with rd_addr=0x0011 rd_hazard=0.
REQ-033 r1 in GRANT1 drops valid with lock=1 for 3 cycles, r0 valid -> r0_ready stays 0; r1 then drops lock -> IDLE, r0 accepted the following cycle.
REQ-034 Accepted beat with wea=0 -> next cycle ena=0, wea=0, rd_hazard=0.
REQ-035 rst asserted during the 3rd beat of an r0 burst -> next cycle ena=0, state IDLE; after release, a tie goes to r0.

Source files
------------

// File: rtl/imem_wr_arbiter.sv
// Two-requester write arbiter for the instruction memory: round-robin on ties,
// locked bursts capped at MAX_BURST beats, one registered write per accepted beat.
module imem_wr_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [31:0]           r0_data,
    input  logic [3:0]            r0_wea,
    input  logic                  r0_lock,
    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [31:0]           r1_data,
    input  logic [3:0]            r1_wea,
    input  logic                  r1_lock,
    output logic                  ena,
    output logic [3:0]            wea,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [31:0]           dina,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_hazard
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    last_q, last_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ena_q, ena_d;
    logic [3:0]              wea_q, wea_d;
    logic [ADDR_WIDTH-1:0]   addra_q, addra_d;
    logic [31:0]             dina_q, dina_d;

    logic                    acc0, acc1, acc;
    logic                    beat_lock;
    logic [3:0]              beat_wea;
    logic [ADDR_WIDTH-1:0]   beat_addr;
    logic [31:0]             beat_data;
    logic                    own_valid, own_lock;
    logic [CNT_W-1:0]        cnt_inc;

    // Ready is purely combinational; last_q=1 means r1 went last, so r0 wins a tie.
    always_comb begin
        r0_ready = 1'b0;
        r1_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (r0_valid && r1_valid) begin
                        r0_ready = last_q;
                        r1_ready = !last_q;
                    end else begin
                        r0_ready = r0_valid;
                        r1_ready = r1_valid;
                    end
                end
                GRANT0:  r0_ready = 1'b1;
                GRANT1:  r1_ready = 1'b1;
                default: ;
            endcase
        end
    end

    assign acc0      = r0_valid && r0_ready;
    assign acc1      = r1_valid && r1_ready;
    assign acc       = acc0 || acc1;
    assign beat_lock = acc1 ? r1_lock : r0_lock;
    assign beat_wea  = acc1 ? r1_wea  : r0_wea;
    assign beat_addr = acc1 ? r1_addr : r0_addr;
    assign beat_data = acc1 ? r1_data : r0_data;
    assign own_valid = (state_q == GRANT1) ? r1_valid : r0_valid;
    assign own_lock  = (state_q == GRANT1) ? r1_lock  : r0_lock;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (acc) begin
            last_d = acc1;
        end
        case (state_q)
            IDLE: begin
                if (acc && beat_lock) begin
                    state_d = acc1 ? GRANT1 : GRANT0;
                    cnt_d   = CNT_W'(1);
                end
            end
            GRANT0, GRANT1: begin
                if (acc) begin
                    cnt_d = cnt_inc;
                    // Forced release at the cap lets the other side in via last_q.
                    if (!beat_lock || cnt_inc == CNT_W'(MAX_BURST)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (!own_valid && !own_lock) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A beat with no byte enables is consumed but never reaches the memory.
    always_comb begin
        ena_d   = acc && (beat_wea != 4'b0000);
        wea_d   = acc ? beat_wea : 4'b0000;
        addra_d = acc ? beat_addr : addra_q;
        dina_d  = acc ? beat_data : dina_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            ena_q   <= 1'b0;
            wea_q   <= 4'b0000;
            addra_q <= '0;
            dina_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ena_q   <= ena_d;
            wea_q   <= wea_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
        end
    end

    assign ena       = ena_q;
    assign wea       = wea_q;
    assign addra     = addra_q;
    assign dina      = dina_q;
    assign rd_hazard = ena_q && (wea_q != 4'b0000) && (addra_q == rd_addr);

endmodule

// File: tb/tb_imem_wr_arbiter.sv
// Randomized bench for imem_wr_arbiter with a behavioural model checked every
// cycle, plus directed scenarios pinned to hand-computed values.
module tb_imem_wr_arbiter;
    localparam int AW = 14;
    localparam int MB = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_valid, r0_lock, r1_valid, r1_lock;
    logic          r0_ready, r1_ready;
    logic [AW-1:0] r0_addr, r1_addr, rd_addr, addra;
    logic [31:0]   r0_data, r1_data, dina;
    logic [3:0]    r0_wea, r1_wea, wea;
    logic          ena, rd_hazard;

    int checks = 0;
    int errors = 0;

    imem_wr_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr),
        .r0_data(r0_data), .r0_wea(r0_wea), .r0_lock(r0_lock),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr),
        .r1_data(r1_data), .r1_wea(r1_wea), .r1_lock(r1_lock),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .rd_addr(rd_addr), .rd_hazard(rd_hazard)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the memory, how many beats it has had, who went last,
    // and the write that must appear on the port next cycle.
    int            owner;
    int            beats;
    int            last;
    bit            m_init = 0;
    bit            m_skip;
    logic          m_ena;
    logic [3:0]    m_wea;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_data;
    logic          e0, e1, b_lock;
    int            who;

    always @(negedge clk) begin
        if (m_init) begin
            chk("ena", ena, m_ena);
            chk("wea", wea, m_wea);
            if (!m_skip) begin
                chk("addra", addra, m_addr);
                chk("dina", dina, m_data);
            end
            chk("rd_hazard", rd_hazard, m_ena && m_wea != 0 && m_addr == rd_addr);
        end
        if (rst) begin
            if (m_init) begin
                chk("r0_ready_rst", r0_ready, 0);
                chk("r1_ready_rst", r1_ready, 0);
            end
            m_init = 1; owner = -1; beats = 0; last = 1; m_skip = 0;
            m_ena = 0; m_wea = 0; m_addr = 0; m_data = 0;
        end else if (m_init) begin
            if (owner == 0)      begin e0 = 1; e1 = 0; end
            else if (owner == 1) begin e0 = 0; e1 = 1; end
            else if (r0_valid && r1_valid) begin e0 = (last == 1); e1 = (last == 0); end
            else begin e0 = r0_valid; e1 = r1_valid; end
            chk("r0_ready", r0_ready, e0);
            chk("r1_ready", r1_ready, e1);
            who = (e0 && r0_valid) ? 0 : (e1 && r1_valid) ? 1 : -1;
            m_ena = 0; m_wea = 0;
            if (who >= 0) begin
                b_lock = (who == 1) ? r1_lock : r0_lock;
                m_wea  = (who == 1) ? r1_wea : r0_wea;
                m_addr = (who == 1) ? r1_addr : r0_addr;
                m_data = (who == 1) ? r1_data : r0_data;
                m_ena  = (m_wea != 0);
                m_skip = !m_ena;
                last   = who;
                if (owner < 0) begin
                    if (b_lock) begin owner = who; beats = 1; end
                end else begin
                    beats++;
                    if (!b_lock || beats == MB) begin owner = -1; beats = 0; end
                end
            end else if (owner >= 0) begin
                if (owner == 0 ? (!r0_valid && !r0_lock) : (!r1_valid && !r1_lock)) begin
                    owner = -1; beats = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        r0_valid = 0; r0_lock = 0; r1_valid = 0; r1_lock = 0;
        r0_wea = 4'hF; r1_wea = 4'hF;
    endtask

    int n1;

    initial begin
        rst = 1; idle_in();
        r0_addr = 0; r1_addr = 0; r0_data = 0; r1_data = 0; rd_addr = 0;
        repeat (3) step();
        rst = 0;

        // Tie with no locks alternates, starting with r0.
        for (int k = 0; k < 4; k++) begin
            r0_valid = 1; r1_valid = 1;
            r0_addr = AW'(16 + k); r1_addr = AW'(32 + k);
            r0_data = 32'hA000_0000 + k; r1_data = 32'hB000_0000 + k;
            @(negedge clk);
            chk("tie_r0_ready", r0_ready, (k % 2 == 0));
            step();
        end
        idle_in();
        @(negedge clk);
        chk("tie_last_ena", ena, 1);
        chk("tie_last_addra", addra, 35);
        chk("tie_last_dina", dina, 32'hB000_0003);
        step();

        // Single write and read-after-write hazard.
        r0_valid = 1; r0_addr = 14'h0010; r0_data = 32'hDEADBEEF; r0_wea = 4'b0101;
        step();
        idle_in(); rd_addr = 14'h0010;
        @(negedge clk);
        chk("wr_ena", ena, 1);
        chk("wr_addra", addra, 14'h0010);
        chk("wr_dina", dina, 32'hDEADBEEF);
        chk("wr_wea", wea, 4'b0101);
        chk("haz_hit", rd_hazard, 1);
        #1 rd_addr = 14'h0011;
        #1 chk("haz_miss", rd_hazard, 0);
        step();

        // Zero-enable beat is swallowed.
        r0_valid = 1; r0_addr = 14'h0022; r0_wea = 4'b0000;
        step();
        idle_in(); rd_addr = 14'h0022;
        @(negedge clk);
        chk("zwea_ena", ena, 0);
        chk("zwea_wea", wea, 0);
        chk("zwea_haz", rd_hazard, 0);
        step();

        // r1 locked burst hits the cap; r0 gets in on the 9th cycle (last=0 so r1 wins the tie).
        n1 = 0;
        for (int k = 0; k < 9; k++) begin
            r0_valid = 1; r0_lock = 0; r1_valid = 1; r1_lock = 1;
            r1_addr = AW'(64 + k);
            @(negedge clk);
            if (r1_ready && r1_valid) n1++;
            if (k == 8) chk("burst_r0_after_cap", r0_ready, 1);
            else        chk("burst_r0_blocked", r0_ready, 0);
            step();
        end
        chk("burst_r1_beats", n1, MB);

        // r1 holds the grant with lock while not valid, then releases.
        r0_valid = 1; r1_valid = 1; r1_lock = 1;
        step();
        for (int k = 0; k < 3; k++) begin
            r1_valid = 0; r1_lock = 1;
            @(negedge clk);
            chk("hold_r0_blocked", r0_ready, 0);
            step();
        end
        r1_lock = 0;
        step();
        @(negedge clk);
        chk("release_r0_ready", r0_ready, 1);
        step();

        // Reset during the 3rd beat of a locked r0 burst.
        idle_in();
        for (int k = 0; k < 3; k++) begin
            r0_valid = 1; r0_lock = 1; r0_addr = AW'(100 + k);
            if (k == 2) rst = 1;
            @(negedge clk);
            if (k == 2) chk("rst_r0_ready", r0_ready, 0);
            step();
        end
        rst = 0; r0_lock = 0; r1_valid = 1;
        @(negedge clk);
        chk("post_rst_ena", ena, 0);
        chk("post_rst_r0_ready", r0_ready, 1);
        chk("post_rst_r1_ready", r1_ready, 0);
        step();

        // Random traffic, small address range so hazards occur.
        for (int k = 0; k < 4000; k++) begin
            rst      = ($urandom_range(299) == 0);
            r0_valid = ($urandom_range(3) != 0);
            r1_valid = ($urandom_range(3) != 0);
            r0_lock  = ($urandom_range(2) != 0);
            r1_lock  = ($urandom_range(2) != 0);
            r0_wea   = ($urandom_range(7) == 0) ? 4'b0000 : 4'($urandom);
            r1_wea   = ($urandom_range(7) == 0) ? 4'b0000 : 4'($urandom);
            r0_addr  = AW'($urandom_range(7));
            r1_addr  = AW'($urandom_range(7));
            r0_data  = $urandom;
            r1_data  = $urandom;
            rd_addr  = AW'($urandom_range(7));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
